mac_accum_pipe: RTL and testbench
=================================

MAC_ACCUM_PIPE -- requirements
Module: mac_accum_pipe

Interface
REQ-001 Parameter DATA_W, default 8, operand width in bits (a, b).
REQ-002 Parameter ACC_W, default 24, accumulator/result width; SHALL satisfy ACC_W >= 2*DATA_W.
REQ-003 Parameter LEN_W, default 8, width of the dot-product length field.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request a new dot product; sampled only in IDLE.
REQ-007 len  input  LEN_W  number of operand pairs; sampled together with start.
REQ-008 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled together with start.
REQ-009 sat_en  input  1  1 = saturate the accumulator, 0 = wrap; sampled together with start.
REQ-010 in_valid  input  1  operand pair valid.
REQ-011 in_ready  output  1  block accepts a pair this cycle.
REQ-012 a, b  input  DATA_W  operands.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 c  output  ACC_W  accumulated result.
REQ-016 overflow  output  1  sticky flag: the accumulator exceeded its range during this dot product.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, ACCUM, DRAIN and HOLD.
REQ-019 IDLE: if start=1 and len!=0, the block SHALL latch len/signed_mode/sat_en, clear acc and overflow, and enter ACCUM; start with len=0 SHALL be ignored.
REQ-020 ACCUM: in_ready=1 while the remaining count is >0; each in_valid&&in_ready transfer SHALL decrement remaining count.
REQ-021 Pipeline: stage 1 SHALL register a and b on transfer; stage 2 SHALL register acc <= acc + a_r*b_r one cycle later.
REQ-022 Accepting the final pair SHALL move the FSM to DRAIN; in_ready SHALL be 0 from the following cycle onward.
REQ-023 DRAIN SHALL last until the final product is in acc, then the FSM SHALL enter HOLD; the final transfer at edge t SHALL yield out_valid=1 after edge t+2.
REQ-024 HOLD: out_valid=1, c=acc, held stable until out_valid&&out_ready, then the FSM SHALL return to IDLE; out_valid SHALL be 0 in every other state.
REQ-025 Products SHALL be sign-extended to ACC_W when signed_mode=1 and zero-extended when signed_mode=0.
REQ-026 sat_en=1: on overflow, acc SHALL clamp to the maximum/minimum of ACC_W in the active signedness; sat_en=0: acc SHALL wrap modulo 2^ACC_W.
REQ-027 overflow SHALL set in both modes and remain set until the next accepted start or reset.
REQ-028 Gaps in in_valid during ACCUM SHALL stall accumulation without loss; operands SHALL not be sampled when in_ready=0.
REQ-029 start outside IDLE SHALL be ignored, with no effect on the running operation.
REQ-030 In IDLE, c SHALL retain the last result.

Reset
REQ-031 reset_n=0 SHALL asynchronously force state=IDLE, acc=0, operand registers=0, count=0, overflow=0, out_valid=0, in_ready=0, busy=0, c=0.
REQ-032 Reset mid-operation SHALL discard the partial sum; no out_valid SHALL follow for that operation.

Structure
REQ-033 The shared package mac_pkg SHALL hold the FSM state type and default width constants (DATA_W, ACC_W, LEN_W).
REQ-034 The saturating/wrapping adder (sum, mode, signedness -> result, overflow) SHALL be the sub-module mac_sat_add.

Verification
REQ-035 Unsigned, sat off, len=3, pairs (2,3),(4,5),(6,7) back-to-back -> c=68, out_valid two cycles after the last transfer, overflow=0.
REQ-036 Signed, DATA_W=8, len=2, pairs (-128,-128),(-1,1) -> c=16383 (24-bit), overflow=0.
REQ-037 Unsigned, ACC_W=16, len=2, pairs (255,255),(255,255): sat_en=1 -> c=0xFFFF, overflow=1; sat_en=0 -> c=0xFC02, overflow=1.
REQ-038 len=4 with in_valid toggling every other cycle, out_ready held low for 5 cycles -> correct sum, c stable throughout HOLD, start during HOLD ignored.
REQ-039 Assert reset_n low after 2 of 4 transfers -> all outputs 0 immediately; next start with len=1, pair (3,3) -> c=9.
REQ-040 start with len=0 -> busy stays 0, in_ready stays 0, no out_valid.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate pipeline:
// default widths, FSM state encoding and the latched per-operation config.
package mac_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 24;
    localparam int LEN_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } mac_state_e;

    // Mode bits captured with start and held for the whole dot product.
    typedef struct packed {
        logic sgn;
        logic sat;
    } mac_cfg_t;

endpackage

// File: rtl/mac_accum_pipe_if.sv
// Command, operand-stream and result handshakes of mac_accum_pipe.
// master: drives start/len/mode, operands and out_ready.
// slave:  the MAC block; returns in_ready, out_valid, c, overflow, busy.
interface mac_accum_pipe_if #(
    parameter int DATA_W = mac_pkg::DATA_W,
    parameter int ACC_W  = mac_pkg::ACC_W,
    parameter int LEN_W  = mac_pkg::LEN_W
) ();

    logic              start;
    logic [LEN_W-1:0]  len;
    logic              signed_mode;
    logic              sat_en;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;

    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  c;
    logic              overflow;
    logic              busy;

    modport master (
        output start, len, signed_mode, sat_en,
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, overflow, busy
    );

    modport slave (
        input  start, len, signed_mode, sat_en,
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, overflow, busy
    );

endinterface

// File: rtl/mac_sat_add.sv
// Accumulator adder with wrap or saturate behaviour.
// Ports: acc_i/add_i operands, signed_i signedness, sat_i clamp enable,
//        sum_o result, ovf_o set when the true sum left the W-bit range.
module mac_sat_add #(
    parameter int W = mac_pkg::ACC_W
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] add_i,
    input  logic         signed_i,
    input  logic         sat_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    logic [W:0]   ext;
    logic [W-1:0] wrap;
    logic [W-1:0] limit;

    always_comb begin
        ext   = {1'b0, acc_i} + {1'b0, add_i};
        wrap  = ext[W-1:0];
        ovf_o = 1'b0;
        limit = '1;
        if (signed_i) begin
            // Signed overflow only when both inputs share a sign
            // and the result does not.
            ovf_o = (acc_i[W-1] == add_i[W-1]) &&
                    (wrap[W-1] != acc_i[W-1]);
            limit = acc_i[W-1] ? {1'b1, {(W-1){1'b0}}}
                               : {1'b0, {(W-1){1'b1}}};
        end else begin
            ovf_o = ext[W];
            limit = '1;
        end
        sum_o = (ovf_o && sat_i) ? limit : wrap;
    end

endmodule

// File: rtl/mac_accum_pipe.sv
// Two-stage pipelined dot-product engine with wrap/saturate accumulation.
// Ports: clk, reset_n (async, active low), bus (slave side of
//        mac_accum_pipe_if: start/len/mode, a/b stream, c/overflow result).
module mac_accum_pipe #(
    parameter int DATA_W = mac_pkg::DATA_W,
    parameter int ACC_W  = mac_pkg::ACC_W,
    parameter int LEN_W  = mac_pkg::LEN_W
) (
    input  logic             clk,
    input  logic             reset_n,
    mac_accum_pipe_if.slave  bus
);

    import mac_pkg::*;

    mac_state_e        state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    mac_cfg_t          cfg_q, cfg_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              pvld_q, pvld_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic              xfer;
    logic [ACC_W-1:0]  opa;
    logic [ACC_W-1:0]  opb;
    logic [ACC_W-1:0]  prod;
    logic [ACC_W-1:0]  add_sum;
    logic              add_ovf;

    assign xfer = bus.in_valid && in_ready_q;

    // Operands are widened to ACC_W before the multiply; since the true
    // product always fits in ACC_W, the truncated result is exact in
    // both signednesses and already carries the right extension.
    always_comb begin
        if (cfg_q.sgn) begin
            opa = ACC_W'($signed(a_q));
            opb = ACC_W'($signed(b_q));
        end else begin
            opa = ACC_W'(a_q);
            opb = ACC_W'(b_q);
        end
        prod = opa * opb;
    end

    mac_sat_add #(
        .W (ACC_W)
    ) u_add (
        .acc_i    (acc_q),
        .add_i    (prod),
        .signed_i (cfg_q.sgn),
        .sat_i    (cfg_q.sat),
        .sum_o    (add_sum),
        .ovf_o    (add_ovf)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cfg_d       = cfg_q;
        a_d         = a_q;
        b_d         = b_q;
        pvld_d      = xfer;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        // Stage 1: capture the pair only on an accepted transfer.
        if (xfer) begin
            a_d = bus.a;
            b_d = bus.b;
        end

        // Stage 2: fold the registered product into the accumulator.
        if (pvld_q) begin
            acc_d = add_sum;
            ovf_d = ovf_q | add_ovf;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && (bus.len != '0)) begin
                    state_d    = ST_ACCUM;
                    cnt_d      = bus.len;
                    cfg_d.sgn  = bus.signed_mode;
                    cfg_d.sat  = bus.sat_en;
                    acc_d      = '0;
                    ovf_d      = 1'b0;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            ST_ACCUM: begin
                if (xfer) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d    = ST_DRAIN;
                        in_ready_d = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                // Once stage 1 is empty, the last product has landed.
                if (!pvld_q) begin
                    state_d     = ST_HOLD;
                    out_valid_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cfg_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            pvld_q      <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cfg_q       <= cfg_d;
            a_q         <= a_d;
            b_q         <= b_d;
            pvld_q      <= pvld_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.c         = acc_q;
    assign bus.overflow  = ovf_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mac_accum_pipe.sv
// Bench for mac_accum_pipe: directed table, corner sequences and
// randomized dot products against an arithmetic reference model.
module tb_mac_accum_pipe;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    mac_accum_pipe_if #(.DATA_W(8), .ACC_W(24), .LEN_W(8)) if8 ();
    mac_accum_pipe_if #(.DATA_W(8), .ACC_W(16), .LEN_W(8)) if16 ();

    mac_accum_pipe #(.DATA_W(8), .ACC_W(24), .LEN_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if8.slave)
    );

    mac_accum_pipe #(.DATA_W(8), .ACC_W(16), .LEN_W(8)) dut16 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if16.slave)
    );

    // The 16-bit instance sees the same stimulus.
    assign if16.start       = if8.start;
    assign if16.len         = if8.len;
    assign if16.signed_mode = if8.signed_mode;
    assign if16.sat_en      = if8.sat_en;
    assign if16.in_valid    = if8.in_valid;
    assign if16.a           = if8.a;
    assign if16.b           = if8.b;
    assign if16.out_ready   = if8.out_ready;

    int checks = 0;
    int failures = 0;
    int pa [16];
    int pb [16];

    typedef struct packed {
        int          n;
        bit          sg;
        bit          st;
        int          gap;
        int          hold;
        bit          w16;
        logic [31:0] ap;
        logic [31:0] bp;
        logic [63:0] ec;
        bit          eo;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint opv(input int v, input bit sg);
        logic [7:0] t;
        t = v[7:0];
        if (sg) return longint'($signed(t));
        return longint'(t);
    endfunction

    // Exact-integer dot product, clamped or wrapped into w bits per step.
    function automatic longint model(input int w, input int n,
                                     input bit sg, input bit st,
                                     output bit ov);
        longint m, lo, hi, acc;
        m   = longint'(1) << w;
        lo  = sg ? -(m / 2) : 0;
        hi  = sg ? (m / 2 - 1) : (m - 1);
        acc = 0;
        ov  = 1'b0;
        for (int i = 0; i < n; i++) begin
            acc += opv(pa[i], sg) * opv(pb[i], sg);
            if (acc > hi || acc < lo) begin
                ov = 1'b1;
                if (st) acc = (acc > hi) ? hi : lo;
                else acc = ((acc - lo) % m + m) % m + lo;
            end
        end
        return acc & (m - 1);
    endfunction

    function automatic int pick();
        case ($urandom_range(0, 4))
            0: return 0;
            1: return 127;
            2: return 128;
            3: return 255;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic do_start(input int n, input bit sg, input bit st);
        if8.in_valid    = 1'b0;
        if8.start       = 1'b1;
        if8.len         = 8'(n);
        if8.signed_mode = sg;
        if8.sat_en      = st;
        tick();
        if8.start       = 1'b0;
        if8.len         = 8'($urandom);
        if8.signed_mode = 1'($urandom);
        if8.sat_en      = 1'($urandom);
    endtask

    // gapmode: 0 back-to-back, 1 alternate cycles, 2 random gaps
    // (with stray start pulses while busy).
    task automatic run_op(input string nm, input int n, input bit sg,
                          input bit st, input int gapmode, input int hold,
                          input bit c24, input longint e24, input bit o24,
                          input bit c16, input longint e16, input bit o16);
        int i, cyc, lat;
        bit v, rdy, stable;
        logic [23:0] h24;
        logic [15:0] h16;
        do_start(n, sg, st);
        i = 0;
        cyc = 0;
        while (i < n && cyc < 400) begin
            if (gapmode == 0) v = 1'b1;
            else if (gapmode == 1) v = (cyc % 2 == 0);
            else v = ($urandom_range(0, 2) != 0);
            if8.in_valid = v;
            if8.a = v ? 8'(pa[i]) : 8'($urandom);
            if8.b = v ? 8'(pb[i]) : 8'($urandom);
            if8.start = (gapmode == 2) && ($urandom_range(0, 7) == 0);
            if8.len = 8'($urandom_range(1, 255));
            rdy = if8.in_ready;
            tick();
            cyc++;
            if (v && rdy) i++;
        end
        if8.start = 1'b0;
        chk({nm, ".xfers"}, 64'(i), 64'(n));
        chk({nm, ".rdy_lo"}, 64'(if8.in_ready), 64'd0);
        // Junk on the stream while not ready must be ignored.
        if8.in_valid = 1'b1;
        if8.a = 8'($urandom);
        if8.b = 8'($urandom);
        lat = 0;
        while (!if8.out_valid && lat < 8) begin
            tick();
            lat++;
        end
        chk({nm, ".lat"}, 64'(lat), 64'd2);
        if (c24) begin
            chk({nm, ".c24"}, 64'(if8.c), 64'(e24));
            chk({nm, ".ovf24"}, 64'(if8.overflow), 64'(o24));
        end
        if (c16) begin
            chk({nm, ".c16"}, 64'(if16.c), 64'(e16));
            chk({nm, ".ovf16"}, 64'(if16.overflow), 64'(o16));
        end
        h24 = if8.c;
        h16 = if16.c;
        stable = 1'b1;
        if8.out_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            if (k == 1) begin
                if8.start = 1'b1;
                if8.len = 8'd1;
            end
            tick();
            if8.start = 1'b0;
            if (!if8.out_valid || !if16.out_valid) stable = 1'b0;
            if (if8.c !== h24 || if16.c !== h16) stable = 1'b0;
        end
        if (hold > 0) chk({nm, ".hold"}, 64'(stable), 64'd1);
        if8.out_ready = 1'b1;
        tick();
        if8.out_ready = 1'b0;
        if8.in_valid = 1'b0;
        chk({nm, ".ov_lo"}, 64'(if8.out_valid), 64'd0);
        chk({nm, ".idle"}, 64'(if8.busy), 64'd0);
        if (c24) chk({nm, ".keep"}, 64'(if8.c), 64'(e24));
        if (c16) chk({nm, ".keep16"}, 64'(if16.c), 64'(e16));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        reset_n = 1'b0;
        if8.start = 1'b0;
        if8.len = '0;
        if8.signed_mode = 1'b0;
        if8.sat_en = 1'b0;
        if8.in_valid = 1'b0;
        if8.a = '0;
        if8.b = '0;
        if8.out_ready = 1'b0;

        tbl[0] = '{n:3, sg:0, st:0, gap:0, hold:0, w16:0,
                   ap:32'h0006_0402, bp:32'h0007_0503,
                   ec:64'd68, eo:0};
        tbl[1] = '{n:2, sg:1, st:0, gap:0, hold:0, w16:0,
                   ap:32'h0000_FF80, bp:32'h0000_0180,
                   ec:64'd16383, eo:0};
        tbl[2] = '{n:2, sg:0, st:1, gap:0, hold:1, w16:1,
                   ap:32'h0000_FFFF, bp:32'h0000_FFFF,
                   ec:64'hFFFF, eo:1};
        tbl[3] = '{n:2, sg:0, st:0, gap:0, hold:1, w16:1,
                   ap:32'h0000_FFFF, bp:32'h0000_FFFF,
                   ec:64'hFC02, eo:1};
        tbl[4] = '{n:2, sg:1, st:1, gap:0, hold:0, w16:1,
                   ap:32'h0000_8080, bp:32'h0000_8080,
                   ec:64'h7FFF, eo:1};
        tbl[5] = '{n:3, sg:1, st:0, gap:0, hold:0, w16:1,
                   ap:32'h0080_8080, bp:32'h007F_7F7F,
                   ec:64'h4180, eo:1};
        tbl[6] = '{n:4, sg:0, st:0, gap:1, hold:5, w16:0,
                   ap:32'h4632_1E0A, bp:32'h503C_2814,
                   ec:64'd10000, eo:0};
        tbl[7] = '{n:4, sg:1, st:1, gap:2, hold:1, w16:0,
                   ap:32'hFF07_CE64, bp:32'h8009_FEFD,
                   ec:64'hFFFFF7, eo:0};

        tick();
        tick();
        chk("rst.c", 64'(if8.c), 64'd0);
        chk("rst.ovf", 64'(if8.overflow), 64'd0);
        chk("rst.busy", 64'(if8.busy), 64'd0);
        chk("rst.rdy", 64'(if8.in_ready), 64'd0);
        chk("rst.ov", 64'(if8.out_valid), 64'd0);
        chk("rst.c16", 64'(if16.c), 64'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++) begin
                pa[j] = int'(tbl[i].ap[8*j +: 8]);
                pb[j] = int'(tbl[i].bp[8*j +: 8]);
            end
            run_op($sformatf("vec%0d", i), tbl[i].n, tbl[i].sg,
                   tbl[i].st, tbl[i].gap, tbl[i].hold,
                   !tbl[i].w16, longint'(tbl[i].ec), tbl[i].eo,
                   tbl[i].w16, longint'(tbl[i].ec), tbl[i].eo);
        end

        // Reset in the middle of an operation.
        do_start(4, 1'b0, 1'b0);
        for (int j = 0; j < 2; j++) begin
            if8.in_valid = 1'b1;
            if8.a = 8'd5;
            if8.b = 8'd5;
            tick();
        end
        if8.in_valid = 1'b0;
        tick();
        chk("mid.partial", 64'(if8.c), 64'd50);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid.c", 64'(if8.c), 64'd0);
        chk("mid.ovf", 64'(if8.overflow), 64'd0);
        chk("mid.busy", 64'(if8.busy), 64'd0);
        chk("mid.rdy", 64'(if8.in_ready), 64'd0);
        chk("mid.ov", 64'(if8.out_valid), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (if8.out_valid || if8.busy) ok = 1'b0;
        end
        chk("mid.quiet", 64'(ok), 64'd1);
        pa[0] = 3;
        pb[0] = 3;
        run_op("mid.next", 1, 1'b0, 1'b0, 0, 0,
               1'b1, 64'd9, 1'b0, 1'b1, 64'd9, 1'b0);

        // Zero-length start is ignored.
        do_start(0, 1'b0, 1'b0);
        chk("len0.busy", 64'(if8.busy), 64'd0);
        chk("len0.rdy", 64'(if8.in_ready), 64'd0);
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (if8.out_valid || if8.busy || if8.in_ready) ok = 1'b0;
        end
        chk("len0.quiet", 64'(ok), 64'd1);

        for (int r = 0; r < 24; r++) begin
            int n;
            bit sg, st, o24, o16;
            longint e24, e16;
            n = $urandom_range(1, 8);
            sg = 1'($urandom_range(0, 1));
            st = 1'($urandom_range(0, 1));
            for (int j = 0; j < n; j++) begin
                pa[j] = pick();
                pb[j] = pick();
            end
            e24 = model(24, n, sg, st, o24);
            e16 = model(16, n, sg, st, o16);
            run_op($sformatf("rnd%0d", r), n, sg, st, 2,
                   $urandom_range(0, 3),
                   1'b1, e24, o24, 1'b1, e16, o16);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
